// File: rtl/wav_dfi_lp_resp_pkg.sv
// Shared types and sizing for the DFI low-power / ctrlupd responder.
package wav_dfi_lp_pkg;

    localparam int ACK_DLY_DEF  = 2;
    localparam int TLP_RESP_DEF = 8;
    localparam int WAKEUP_W     = 6;
    localparam int WCNT_W       = 7;
    localparam int CNT_W        = $clog2(TLP_RESP_DEF + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LP   = 2'd2,
        WAKE = 2'd3
    } lp_state_e;

    function automatic int cnt_width(input int tlp_resp);
        return $clog2(tlp_resp + 1);
    endfunction

endpackage

// File: rtl/wav_dfi_lp_resp_if.sv
// DFI low-power / ctrlupd handshake bundle between controller side and PHY responder.
interface wav_dfi_lp_resp_if;
    import wav_dfi_lp_pkg::*;

    logic                cfg_lp_ctrl_en;
    logic                cfg_lp_data_en;
    logic                phy_busy;
    logic                lp_ctrl_req;
    logic [WAKEUP_W-1:0] lp_ctrl_wakeup;
    logic                lp_ctrl_ack;
    logic                lp_data_req;
    logic [WAKEUP_W-1:0] lp_data_wakeup;
    logic                lp_data_ack;
    logic                ctrlupd_req;
    logic                ctrlupd_ack;
    logic                lp_ctrl_active;
    logic                lp_data_active;
    logic                lp_ctrl_waking;
    logic                lp_data_waking;
    logic                lp_ctrl_timeout;
    logic                lp_data_timeout;

    modport master (
        output cfg_lp_ctrl_en, cfg_lp_data_en, phy_busy,
        output lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, ctrlupd_req,
        input  lp_ctrl_ack, lp_data_ack, ctrlupd_ack,
        input  lp_ctrl_active, lp_data_active, lp_ctrl_waking, lp_data_waking,
        input  lp_ctrl_timeout, lp_data_timeout
    );

    modport slave (
        input  cfg_lp_ctrl_en, cfg_lp_data_en, phy_busy,
        input  lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, ctrlupd_req,
        output lp_ctrl_ack, lp_data_ack, ctrlupd_ack,
        output lp_ctrl_active, lp_data_active, lp_ctrl_waking, lp_data_waking,
        output lp_ctrl_timeout, lp_data_timeout
    );

endinterface

// File: rtl/wav_dfi_lp_resp_chan.sv
// One DFI low-power channel: IDLE/PEND/LP/WAKE FSM with grant window, timeout and wake countdown.
module wav_dfi_lp_chan
    import wav_dfi_lp_pkg::*;
#(
    parameter int ACK_DLY  = ACK_DLY_DEF,
    parameter int TLP_RESP = TLP_RESP_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_req,
    input  logic [WAKEUP_W-1:0] i_wakeup,
    input  logic                i_en,
    input  logic                i_phy_busy,
    input  logic                i_inhibit,
    output logic                o_ack,
    output logic                o_active,
    output logic                o_waking,
    output logic                o_timeout,
    output logic                o_idle
);
    localparam int CW = cnt_width(TLP_RESP);
    localparam logic [CW-1:0] C_ACK = CW'(ACK_DLY);
    localparam logic [CW-1:0] C_TLP = CW'(TLP_RESP);

    lp_state_e           r_state, w_state_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt;
    logic [WAKEUP_W-1:0] r_wakeup, w_wakeup_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                w_grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wcnt    <= '0;
            r_wakeup  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_wakeup  <= w_wakeup_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // The grant window is a single cycle; a missed window leaves the request
    // pending until it times out or is withdrawn.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wcnt_nxt    = r_wcnt;
        w_wakeup_nxt  = r_wakeup;
        w_timeout_nxt = 1'b0;
        w_grant       = (r_cnt == C_ACK) && i_en && !i_phy_busy;
        case (r_state)
            IDLE: begin
                if (i_req && !i_inhibit) begin
                    w_state_nxt = PEND;
                    w_cnt_nxt   = CW'(1);
                end
            end
            PEND: begin
                if (!i_req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_grant) begin
                    w_state_nxt  = LP;
                    w_cnt_nxt    = '0;
                    w_wakeup_nxt = i_wakeup;
                end else if (r_cnt != C_TLP) begin
                    w_cnt_nxt     = r_cnt + CW'(1);
                    w_timeout_nxt = (r_cnt == C_TLP - CW'(1));
                end
            end
            LP: begin
                if (i_req) begin
                    w_wakeup_nxt = i_wakeup;
                end else begin
                    w_state_nxt = WAKE;
                    w_wcnt_nxt  = {1'b0, r_wakeup} + WCNT_W'(1);
                end
            end
            WAKE: begin
                if (r_wcnt == WCNT_W'(1)) begin
                    w_state_nxt = IDLE;
                    w_wcnt_nxt  = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt - WCNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_ack     = (r_state == LP);
    assign o_active  = (r_state == LP);
    assign o_waking  = (r_state == WAKE);
    assign o_idle    = (r_state == IDLE);
    assign o_timeout = r_timeout;

endmodule

// File: rtl/wav_dfi_lp_resp.sv
// PHY-side DFI responder: two LP channels plus the ctrlupd grant that holds them off.
module wav_dfi_lp_resp
    import wav_dfi_lp_pkg::*;
#(
    parameter int ACK_DLY  = ACK_DLY_DEF,
    parameter int TLP_RESP = TLP_RESP_DEF
) (
    input  logic             clock,
    input  logic             reset,
    wav_dfi_lp_resp_if.slave bus
);
    localparam int NCH = 2;

    logic [NCH-1:0]               w_req, w_en, w_ack, w_active, w_waking, w_timeout, w_idle;
    logic [NCH-1:0][WAKEUP_W-1:0] w_wakeup;
    logic                         r_upd_grant, w_upd_grant_nxt;

    assign w_req    = {bus.lp_data_req,    bus.lp_ctrl_req};
    assign w_en     = {bus.cfg_lp_data_en, bus.cfg_lp_ctrl_en};
    assign w_wakeup = {bus.lp_data_wakeup, bus.lp_ctrl_wakeup};

    // Inhibit uses the next grant value so a ctrlupd rising on the same edge
    // as an LP request keeps that channel in IDLE.
    assign w_upd_grant_nxt = bus.ctrlupd_req & (r_upd_grant | (~bus.phy_busy & (&w_idle)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_upd_grant <= 1'b0;
        else        r_upd_grant <= w_upd_grant_nxt;
    end

    assign bus.ctrlupd_ack = bus.ctrlupd_req & r_upd_grant;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        wav_dfi_lp_chan #(
            .ACK_DLY  (ACK_DLY),
            .TLP_RESP (TLP_RESP)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .i_req      (w_req[g]),
            .i_wakeup   (w_wakeup[g]),
            .i_en       (w_en[g]),
            .i_phy_busy (bus.phy_busy),
            .i_inhibit  (w_upd_grant_nxt),
            .o_ack      (w_ack[g]),
            .o_active   (w_active[g]),
            .o_waking   (w_waking[g]),
            .o_timeout  (w_timeout[g]),
            .o_idle     (w_idle[g])
        );
    end

    assign bus.lp_ctrl_ack     = w_ack[0];
    assign bus.lp_data_ack     = w_ack[1];
    assign bus.lp_ctrl_active  = w_active[0];
    assign bus.lp_data_active  = w_active[1];
    assign bus.lp_ctrl_waking  = w_waking[0];
    assign bus.lp_data_waking  = w_waking[1];
    assign bus.lp_ctrl_timeout = w_timeout[0];
    assign bus.lp_data_timeout = w_timeout[1];

endmodule

// File: tb/tb_wav_dfi_lp_resp.sv
// Vector-table bench for wav_dfi_lp_resp with a queue of expected post-edge outputs.
module tb_wav_dfi_lp_resp;

    logic clock;
    logic reset;

    wav_dfi_lp_resp_if bus();

    wav_dfi_lp_resp #(.ACK_DLY(2), .TLP_RESP(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // e = {pre-edge upd_ack, upd_ack, to_d, to_c, wk_d, wk_c, ack_d, ack_c}
    typedef struct {
        logic       rc, rd, upd, busy, ec, ed;
        logic [5:0] wc, wd;
        logic [7:0] e;
    } vec_t;

    vec_t       tbl[$];
    logic [8:0] sb_q[$];
    int         rst_at;
    int         cur_row;
    int         n_chk;
    int         n_fail;
    logic [8:0] dut_out;

    assign dut_out = {bus.ctrlupd_ack, bus.lp_data_timeout, bus.lp_ctrl_timeout,
                      bus.lp_data_waking, bus.lp_ctrl_waking,
                      bus.lp_data_active, bus.lp_ctrl_active,
                      bus.lp_data_ack, bus.lp_ctrl_ack};

    task automatic add(input logic rc, rd, upd, busy, ec, ed,
                       input logic [5:0] wc, wd, input logic [7:0] e);
        vec_t v;
        v.rc = rc; v.rd = rd; v.upd = upd; v.busy = busy; v.ec = ec; v.ed = ed;
        v.wc = wc; v.wd = wd; v.e = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b want %b", nm, cur_row, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        logic [8:0] exp;
        bus.lp_ctrl_req    = v.rc;
        bus.lp_data_req    = v.rd;
        bus.ctrlupd_req    = v.upd;
        bus.phy_busy       = v.busy;
        bus.cfg_lp_ctrl_en = v.ec;
        bus.cfg_lp_data_en = v.ed;
        bus.lp_ctrl_wakeup = v.wc;
        bus.lp_data_wakeup = v.wd;
        sb_q.push_back({v.e[6:2], v.e[1:0], v.e[1:0]});
        #1;
        check("pre_upd_ack", {8'b0, bus.ctrlupd_ack}, {8'b0, v.e[7]});
        @(posedge clock);
        #1;
        exp = sb_q.pop_front();
        check("post_edge", dut_out, exp);
    endtask

    task automatic reset_mid_op();
        reset = 1'b0;
        #1;
        check("rst_async", dut_out, 9'b0);
        @(posedge clock);
        #1;
        check("rst_hold", dut_out, 9'b0);
        reset = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cur_row = -1;
        reset = 1'b0;
        bus.lp_ctrl_req = 0; bus.lp_data_req = 0; bus.ctrlupd_req = 0; bus.phy_busy = 0;
        bus.cfg_lp_ctrl_en = 0; bus.cfg_lp_data_en = 0;
        bus.lp_ctrl_wakeup = '0; bus.lp_data_wakeup = '0;

        // ctrl basic: ack after E2, WAKE for wakeup+1 = 4 cycles
        repeat (2) add(1,0,0,0,1,1,3,0,8'h00);
        repeat (2) add(1,0,0,0,1,1,3,0,8'h01);
        repeat (4) add(0,0,0,0,1,1,3,0,8'h04);
        add(0,0,0,0,1,1,3,0,8'h00);
        // data disabled: no ack, one timeout pulse after E7
        repeat (7) add(0,1,0,0,1,0,0,5,8'h00);
        add(0,1,0,0,1,0,0,5,8'h20);
        repeat (2) add(0,1,0,0,1,0,0,5,8'h00);
        add(0,0,0,0,1,0,0,5,8'h00);
        // phy_busy at cnt==2 kills the grant; fresh request later acks normally
        repeat (2) add(1,0,0,0,1,1,0,0,8'h00);
        add(1,0,0,1,1,1,0,0,8'h00);
        repeat (4) add(1,0,0,0,1,1,0,0,8'h00);
        add(1,0,0,0,1,1,0,0,8'h10);
        add(1,0,0,0,1,1,0,0,8'h00);
        add(0,0,0,0,1,1,0,0,8'h00);
        repeat (2) add(1,0,0,0,1,1,0,0,8'h00);
        add(1,0,0,0,1,1,0,0,8'h01);
        add(0,0,0,0,1,1,0,0,8'h04);
        add(0,0,0,0,1,1,0,0,8'h00);
        // ctrlupd and lp_ctrl rise together: ctrlupd wins
        add(1,0,1,0,1,1,0,0,8'h40);
        add(1,0,1,0,1,1,0,0,8'hC0);
        repeat (2) add(1,0,0,0,1,1,0,0,8'h00);
        add(1,0,0,0,1,1,0,0,8'h01);
        add(0,0,0,0,1,1,0,0,8'h04);
        add(0,0,0,0,1,1,0,0,8'h00);
        // ctrlupd refused while a channel is not IDLE, or while phy_busy
        add(1,0,0,0,1,1,0,0,8'h00);
        add(1,0,1,0,1,1,0,0,8'h00);
        add(1,0,1,0,1,1,0,0,8'h01);
        add(0,0,1,0,1,1,0,0,8'h04);
        add(0,0,1,0,1,1,0,0,8'h00);
        add(0,0,1,0,1,1,0,0,8'h40);
        add(0,0,1,0,1,1,0,0,8'hC0);
        add(0,0,0,0,1,1,0,0,8'h00);
        add(0,0,1,1,1,1,0,0,8'h00);
        add(0,0,0,0,1,1,0,0,8'h00);
        // wakeup recaptured 3 -> 10: WAKE 11 cycles; req during WAKE ignored
        repeat (2) add(1,0,0,0,1,1,3,0,8'h00);
        add(1,0,0,0,1,1,3,0,8'h01);
        add(1,0,0,0,1,1,10,0,8'h01);
        repeat (5) add(0,0,0,0,1,1,10,0,8'h04);
        repeat (6) add(1,0,0,0,1,1,10,0,8'h04);
        repeat (3) add(1,0,0,0,1,1,0,0,8'h00);
        add(1,0,0,0,1,1,0,0,8'h01);
        add(0,0,0,0,1,1,0,0,8'h04);
        add(0,0,0,0,1,1,0,0,8'h00);
        // both channels together, independent wake lengths
        repeat (2) add(1,1,0,0,1,1,1,2,8'h00);
        add(1,1,0,0,1,1,1,2,8'h03);
        add(0,1,0,0,1,1,1,2,8'h06);
        add(0,0,0,0,1,1,1,2,8'h0C);
        repeat (2) add(0,0,0,0,1,1,1,2,8'h08);
        add(0,0,0,0,1,1,1,2,8'h00);
        // both in LP, reset asserted, then released with reqs held high
        repeat (2) add(1,1,0,0,1,1,5,5,8'h00);
        add(1,1,0,0,1,1,5,5,8'h03);
        rst_at = tbl.size();
        repeat (2) add(1,1,0,0,1,1,5,5,8'h00);
        add(1,1,0,0,1,1,5,5,8'h03);
        repeat (6) add(0,0,0,0,1,1,5,5,8'h0C);
        add(0,0,0,0,1,1,5,5,8'h00);

        repeat (2) @(posedge clock);
        #1;
        check("reset_state", dut_out, 9'b0);
        reset = 1'b1;
        #1;
        check("after_release", dut_out, 9'b0);

        foreach (tbl[i]) begin
            cur_row = i;
            if (i == rst_at) reset_mid_op();
            step(tbl[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
